wb_axi_write_arbiter: RTL and testbench



---
 rtl/wb_axi_write_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wb_axi_write_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI4 write path (AW/W/B) between NUM_REQ
// single-beat Wishbone-style write requesters, one transaction in flight.
module wb_axi_write_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_sel,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [NUM_REQ-1:0]              req_err,
  output logic [ID_WIDTH-1:0]             axi_awid,
  output logic [ADDR_WIDTH-1:0]           axi_awaddr,
  output logic [7:0]                      axi_awlen,
  output logic [2:0]                      axi_awsize,
  output logic [1:0]                      axi_awburst,
  output logic                            axi_awvalid,
  input  logic                            axi_awready,
  output logic [DATA_WIDTH-1:0]           axi_wdata,
  output logic [DATA_WIDTH/8-1:0]         axi_wstrb,
  output logic                            axi_wlast,
  output logic                            axi_wvalid,
  input  logic                            axi_wready,
  input  logic [ID_WIDTH-1:0]             axi_bid,
  input  logic [1:0]                      axi_bresp,
  input  logic                            axi_bvalid,
  output logic                            axi_bready,
  output logic                            busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_B,
    DONE
  } state_t;

  state_t                 state, state_n;
  logic [PTR_WIDTH-1:0]   rr_ptr;
  logic [PTR_WIDTH-1:0]   gnt;
  logic [CNT_WIDTH-1:0]   tcnt;

  logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];
  logic [STRB_WIDTH-1:0]  sel_arr  [NUM_REQ];

  logic                   found;
  logic [PTR_WIDTH-1:0]   pick;
  logic [PTR_WIDTH-1:0]   cand;
  logic                   aw_hs, w_hs, b_hs;
  logic                   b_err, timeout;
  logic [NUM_REQ-1:0]     gnt_onehot;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign sel_arr[g]  = req_sel[g*STRB_WIDTH +: STRB_WIDTH];
  end

  assign axi_awlen   = 8'd0;
  assign axi_awsize  = 3'($clog2(STRB_WIDTH));
  assign axi_awburst = 2'b01;
  assign axi_wlast   = 1'b1;
  assign busy        = (state != IDLE);

  assign aw_hs      = axi_awvalid & axi_awready;
  assign w_hs       = axi_wvalid & axi_wready;
  assign b_hs       = axi_bvalid & axi_bready;
  assign b_err      = axi_bresp[1] | (axi_bid != axi_awid);
  assign timeout    = (TIMEOUT_CYCLES != 0) && (tcnt == CNT_LAST);
  assign gnt_onehot = NUM_REQ'(1) << gnt;

  // Rotating search from rr_ptr; the first asserted request wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_WIDTH'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (found) state_n = ISSUE;
      ISSUE:   if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready))
                 state_n = WAIT_B;
      WAIT_B:  if (b_hs || timeout) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rr_ptr      <= '0;
      gnt         <= '0;
      tcnt        <= '0;
      axi_awid    <= '0;
      axi_awaddr  <= '0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      req_ack     <= '0;
      req_err     <= '0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt         <= pick;
            axi_awid    <= ID_WIDTH'(pick);
            axi_awaddr  <= addr_arr[pick];
            axi_wdata   <= data_arr[pick];
            axi_wstrb   <= sel_arr[pick];
            rr_ptr      <= (pick == PTR_LAST) ? '0 : pick + 1'b1;
            axi_awvalid <= 1'b1;
            axi_wvalid  <= 1'b1;
          end
        end
        ISSUE: begin
          if (aw_hs) axi_awvalid <= 1'b0;
          if (w_hs)  axi_wvalid  <= 1'b0;
          if (state_n == WAIT_B) begin
            axi_bready <= 1'b1;
            tcnt       <= '0;
          end
        end
        WAIT_B: begin
          // A response in the timeout cycle still wins over the timeout.
          if (b_hs || timeout) begin
            axi_bready <= 1'b0;
            if (b_hs ? b_err : 1'b1) req_err <= gnt_onehot;
            else                     req_ack <= gnt_onehot;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_axi_write_arbiter.sv
// Scoreboard bench for wb_axi_write_arbiter: directed requests push expected
// AXI beats and completions; a monitor pops and compares at each DUT output.
module tb_wb_axi_write_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int IW = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR*SW-1:0] req_sel;
  logic [NR-1:0]  req_ack, req_err;
  logic [IW-1:0]  awid;
  logic [AW-1:0]  awaddr;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic           awvalid, awready;
  logic [DW-1:0]  wdata;
  logic [SW-1:0]  wstrb;
  logic           wlast, wvalid, wready;
  logic [IW-1:0]  bid;
  logic [1:0]     bresp;
  logic           bvalid, bready;
  logic           busy;

  logic [AW-1:0]  p_addr [NR];
  logic [DW-1:0]  p_data [NR];
  logic [SW-1:0]  p_sel  [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_addr[g*AW +: AW] = p_addr[g];
    assign req_data[g*DW +: DW] = p_data[g];
    assign req_sel[g*SW +: SW]  = p_sel[g];
  end

  wb_axi_write_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
    .req_ack(req_ack), .req_err(req_err),
    .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
    .axi_awburst(awburst), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
    .axi_wready(wready),
    .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic note_fail(input string name);
    n_total++;
    $display("FAIL %s: event not expected / did not occur (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    bit            err;
    int            bcyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input int idx, input bit err, input int bcyc);
    exp_t e;
    e.idx  = idx;
    e.addr = p_addr[idx];
    e.data = p_data[idx];
    e.strb = p_sel[idx];
    e.err  = err;
    e.bcyc = bcyc;
    exp_q.push_back(e);
  endtask

  // Slave model
  int         aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
  bit         b_en = 1'b1, b_force = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
  bit         b_hs = 1'b0, bid_ovr_en = 1'b0;
  logic [1:0] cfg_bresp = 2'b00;
  logic [IW-1:0] bid_ovr = '0, seen_id = '0;

  initial begin : slave
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_seen = 1'b0; w_seen = 1'b0; b_hs = 1'b0;
      end else begin
        if (awvalid && awready) begin aw_seen = 1'b1; seen_id = awid; end
        if (wvalid && wready) w_seen = 1'b1;
        b_hs = bvalid && bready;
        if (|req_ack || |req_err) begin aw_seen = 1'b0; w_seen = 1'b0; end
      end
      @(posedge clk); #1;
      if (b_hs) begin aw_seen = 1'b0; w_seen = 1'b0; b_hs = 1'b0; end
      if (!awvalid) aw_wait = 0;
      awready = awvalid && (aw_wait >= aw_delay);
      if (awvalid) aw_wait++;
      if (!wvalid) w_wait = 0;
      wready = wvalid && (w_wait >= w_delay);
      if (wvalid) w_wait++;
      bvalid = b_force || (b_en && aw_seen && w_seen);
      bresp  = cfg_bresp;
      bid    = bid_ovr_en ? bid_ovr : seen_id;
    end
  end

  // Monitor / scoreboard
  int bcnt    = 0;
  bit aw_done = 1'b0, w_done = 1'b0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0; aw_done = 1'b0; w_done = 1'b0;
      end else begin
        if (aw_done) chk("awvalid_low_after_hs", awvalid, 0);
        if (w_done)  chk("wvalid_low_after_hs", wvalid, 0);
        if (bready) begin
          bcnt++;
          chk("issue_closed_in_wait_b", {awvalid, wvalid}, 0);
        end
        if (awvalid && awready) begin
          if (exp_q.size() == 0) note_fail("aw_unexpected");
          else begin
            e = exp_q[0];
            chk("awid", awid, e.idx);
            chk("awaddr", awaddr, e.addr);
            chk("aw_len_size_burst", {awlen, awsize, awburst}, {8'd0, 3'd2, 2'b01});
          end
          aw_done = 1'b1;
        end
        if (wvalid && wready) begin
          if (exp_q.size() == 0) note_fail("w_unexpected");
          else begin
            e = exp_q[0];
            chk("wdata", wdata, e.data);
            chk("wstrb", wstrb, e.strb);
            chk("wlast", wlast, 1);
          end
          w_done = 1'b1;
        end
        if (|req_ack || |req_err) begin
          if (exp_q.size() == 0) note_fail("completion_unexpected");
          else begin
            e = exp_q.pop_front();
            chk("req_ack", req_ack, e.err ? '0 : (NR'(1) << e.idx));
            chk("req_err", req_err, e.err ? (NR'(1) << e.idx) : '0);
            chk("wait_b_cycles", bcnt, e.bcyc);
          end
          bcnt = 0; aw_done = 1'b0; w_done = 1'b0;
        end
      end
    end
  end

  task automatic do_req(input int idx, input bit err, input int bcyc, output int lat);
    logic [NR-1:0] m;
    int            start;
    bit            got;
    m = NR'(1) << idx;
    push(idx, err, bcyc);
    @(posedge clk); #1;
    req_valid = req_valid | m;
    start = cyc;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (|((req_ack | req_err) & m)) got = 1'b1;
    end
    lat = cyc - start;
    if (!got) note_fail("request_completion_timeout");
    @(posedge clk); #1;
    req_valid = req_valid & ~m;
  endtask

  task automatic run_both(input int n);
    int got;
    got = 0;
    @(posedge clk); #1;
    req_valid = '1;
    for (int k = 0; k < 40 * n && got < n; k++) begin
      @(negedge clk);
      if (|req_ack || |req_err) got++;
    end
    chk("both_held_pulse_count", got, n);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic set_pay(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
    p_addr[idx] = a;
    p_data[idx] = d;
    p_sel[idx]  = s;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    bit seen;
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NR; i++) set_pay(i, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valids", {awvalid, wvalid, bready}, 0);
    chk("reset_pulses", {req_ack, req_err}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_latched", {awid, awaddr, wdata, wstrb}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request, minimum latency
    set_pay(0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    do_req(0, 1'b0, 1, lat);
    chk("min_latency", lat, 3);
    chk("busy_after_done", busy, 0);

    // req1 alone brings rr_ptr back to 0
    set_pay(1, 32'h0000_2004, 32'h1234_5678, 4'h3);
    do_req(1, 1'b0, 1, lat);

    // Both held: strict alternation 0,1,0,1
    set_pay(0, 32'h0000_3000, 32'hA5A5_A5A5, 4'hF);
    set_pay(1, 32'h0000_4008, 32'h0F0F_0F0F, 4'hC);
    push(0, 1'b0, 1); push(1, 1'b0, 1); push(0, 1'b0, 1); push(1, 1'b0, 1);
    run_both(4);

    // AW delayed, W immediate; then the reverse
    aw_delay = 3; w_delay = 0;
    set_pay(0, 32'h0000_5000, 32'h1111_2222, 4'h1);
    do_req(0, 1'b0, 1, lat);
    chk("aw_delayed_latency", lat, 6);
    aw_delay = 0; w_delay = 3;
    set_pay(1, 32'h0000_6000, 32'h3333_4444, 4'h8);
    do_req(1, 1'b0, 1, lat);
    chk("w_delayed_latency", lat, 6);
    w_delay = 0;

    // SLVERR, then an ID mismatch on requester 1
    cfg_bresp = 2'b10;
    set_pay(0, 32'h0000_7000, 32'h5555_6666, 4'hF);
    do_req(0, 1'b1, 1, lat);
    cfg_bresp = 2'b00;
    bid_ovr_en = 1'b1; bid_ovr = 4'd3;
    set_pay(1, 32'h0000_8000, 32'h7777_8888, 4'hF);
    do_req(1, 1'b1, 1, lat);
    bid_ovr_en = 1'b0;

    // No response: timeout after TO cycles in WAIT_B, late bvalid ignored
    b_en = 1'b0;
    set_pay(0, 32'h0000_9000, 32'h9999_AAAA, 4'h6);
    do_req(0, 1'b1, TO, lat);
    b_force = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("late_bvalid_bready", bready, 0);
      chk("late_bvalid_busy", busy, 0);
    end
    b_force = 1'b0;
    b_en = 1'b1;
    repeat (2) @(posedge clk);

    // Reset in ISSUE abandons the transfer and restarts arbitration at 0
    aw_delay = 5; w_delay = 5;
    set_pay(0, 32'h0000_A000, 32'hBBBB_CCCC, 4'hF);
    @(posedge clk); #1;
    req_valid = 2'b01;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (awvalid) seen = 1'b1;
    end
    if (!seen) note_fail("awvalid_never_raised");
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("async_reset_valids", {awvalid, wvalid}, 0);
    chk("async_reset_pulses", {req_ack, req_err}, 0);
    chk("async_reset_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    aw_delay = 0; w_delay = 0;
    set_pay(0, 32'h0000_B000, 32'hCAFE_F00D, 4'hF);
    set_pay(1, 32'h0000_C004, 32'hFACE_B00C, 4'h3);
    push(0, 1'b0, 1); push(1, 1'b0, 1);
    run_both(2);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
